// File: rtl/sdio_data_control.sv
// SDIO data-path sequencer: splits a CMD53 transfer into per-block PHY activations with gaps, CRC tokens and abort.
// Optional build macro SDIO_DATA_TIMEOUT_EN adds a per-block ACTIVE watchdog and the o_timeout output.
module sdio_data_control #(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_xfer_start,
  input  logic        i_write_flag,
  input  logic        i_block_mode,
  input  logic [8:0]  i_byte_count,
  input  logic [11:0] i_block_size,
  input  logic [8:0]  i_block_count,
  input  logic        i_abort,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_aborted,
  output logic        o_crc_error,
  output logic [8:0]  o_blocks_done,
  output logic        o_crc_status_stb,
  output logic [2:0]  o_crc_status,
  output logic        o_phy_activate,
  output logic        o_phy_write_flag,
  output logic [12:0] o_phy_data_count,
  input  logic        i_phy_finished,
  input  logic        i_phy_crc_good,
`ifdef SDIO_DATA_TIMEOUT_EN
  output logic        o_timeout,
`endif
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_ACTIVE  = 3'd2,
    S_RELEASE = 3'd3,
    S_GAP     = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  localparam int                GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [2:0]        TOK_GOOD = 3'b010;
  localparam logic [2:0]        TOK_BAD  = 3'b101;

  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("GAP_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit a 16-bit counter");
  end

  state_e           state_q, state_d;
  logic             write_q, write_d;
  logic             block_mode_q, block_mode_d;
  logic [12:0]      len_q, len_d;
  logic [8:0]       block_count_q, block_count_d;
  logic [8:0]       blocks_done_q, blocks_done_d;
  logic             aborted_q, aborted_d;
  logic             crc_error_q, crc_error_d;
  logic             stb_q, stb_d;
  logic [2:0]       token_q, token_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
`ifdef SDIO_DATA_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]      to_cnt_q, to_cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // PHY handshake: activate is held high from ACTIVE entry until the cycle after
  // i_phy_finished is seen; count/flag are registered before SETUP and held.
  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    block_mode_d  = block_mode_q;
    len_d         = len_q;
    block_count_d = block_count_q;
    blocks_done_d = blocks_done_q;
    aborted_d     = aborted_q;
    crc_error_d   = crc_error_q;
    stb_d         = 1'b0;
    token_d       = token_q;
    gap_cnt_d     = gap_cnt_q;
`ifdef SDIO_DATA_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    timeout_d     = timeout_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (i_xfer_start) begin
          write_d       = i_write_flag;
          block_mode_d  = i_block_mode;
          block_count_d = i_block_count;
          if (i_block_mode) begin
            len_d = (i_block_size == 12'd0) ? 13'd2048 : {1'b0, i_block_size};
          end else begin
            len_d = (i_byte_count == 9'd0) ? 13'd512 : {4'd0, i_byte_count};
          end
          aborted_d     = 1'b0;
          crc_error_d   = 1'b0;
          blocks_done_d = 9'd0;
`ifdef SDIO_DATA_TIMEOUT_EN
          timeout_d     = 1'b0;
`endif
          state_d       = S_SETUP;
        end
      end

      S_SETUP: begin
`ifdef SDIO_DATA_TIMEOUT_EN
        to_cnt_d = 16'd0;
`endif
        state_d = S_ACTIVE;
      end

      S_ACTIVE: begin
`ifdef SDIO_DATA_TIMEOUT_EN
        to_cnt_d = to_cnt_q + 16'd1;
`endif
        if (i_phy_finished) begin
          blocks_done_d = blocks_done_q + 9'd1;
          if (write_q) begin
            stb_d   = 1'b1;
            token_d = i_phy_crc_good ? TOK_GOOD : TOK_BAD;
            if (!i_phy_crc_good) crc_error_d = 1'b1;
          end
          state_d = S_RELEASE;
        end
`ifdef SDIO_DATA_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
`endif
      end

      S_RELEASE: begin
        gap_cnt_d = '0;
        if (crc_error_q || !block_mode_q ||
            (block_count_q != 9'd0 && blocks_done_q == block_count_q)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_SETUP;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Abort overrides the next state but keeps any block completion recorded above.
    if (i_abort && state_q != S_IDLE && state_q != S_DONE) begin
      aborted_d = 1'b1;
      state_d   = S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      write_q       <= 1'b0;
      block_mode_q  <= 1'b0;
      len_q         <= 13'd0;
      block_count_q <= 9'd0;
      blocks_done_q <= 9'd0;
      aborted_q     <= 1'b0;
      crc_error_q   <= 1'b0;
      stb_q         <= 1'b0;
      token_q       <= 3'd0;
      gap_cnt_q     <= '0;
`ifdef SDIO_DATA_TIMEOUT_EN
      to_cnt_q      <= 16'd0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      block_mode_q  <= block_mode_d;
      len_q         <= len_d;
      block_count_q <= block_count_d;
      blocks_done_q <= blocks_done_d;
      aborted_q     <= aborted_d;
      crc_error_q   <= crc_error_d;
      stb_q         <= stb_d;
      token_q       <= token_d;
      gap_cnt_q     <= gap_cnt_d;
`ifdef SDIO_DATA_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  assign o_busy           = (state_q == S_SETUP) || (state_q == S_ACTIVE) ||
                            (state_q == S_RELEASE) || (state_q == S_GAP);
  assign o_done           = (state_q == S_DONE);
  assign o_phy_activate   = (state_q == S_ACTIVE);
  assign o_aborted        = aborted_q;
  assign o_crc_error      = crc_error_q;
  assign o_blocks_done    = blocks_done_q;
  assign o_crc_status_stb = stb_q;
  assign o_crc_status     = token_q;
  assign o_phy_write_flag = write_q;
  assign o_phy_data_count = len_q;
  assign o_dbg_state      = state_q;
`ifdef SDIO_DATA_TIMEOUT_EN
  assign o_timeout        = timeout_q;
`endif

endmodule

// File: tb/tb_sdio_data_control.sv
// Self-checking bench for sdio_data_control: task-driven PHY model, token/length scoreboard queues.
module tb_sdio_data_control;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_xfer_start, i_write_flag, i_block_mode, i_abort;
  logic [8:0]  i_byte_count, i_block_count;
  logic [11:0] i_block_size;
  logic        o_busy, o_done, o_aborted, o_crc_error, o_crc_status_stb;
  logic [8:0]  o_blocks_done;
  logic [2:0]  o_crc_status;
  logic        o_phy_activate, o_phy_write_flag;
  logic [12:0] o_phy_data_count;
  logic        i_phy_finished, i_phy_crc_good;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  sdio_data_control #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst),
    .i_xfer_start(i_xfer_start), .i_write_flag(i_write_flag), .i_block_mode(i_block_mode),
    .i_byte_count(i_byte_count), .i_block_size(i_block_size), .i_block_count(i_block_count),
    .i_abort(i_abort),
    .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted), .o_crc_error(o_crc_error),
    .o_blocks_done(o_blocks_done), .o_crc_status_stb(o_crc_status_stb), .o_crc_status(o_crc_status),
    .o_phy_activate(o_phy_activate), .o_phy_write_flag(o_phy_write_flag),
    .o_phy_data_count(o_phy_data_count),
    .i_phy_finished(i_phy_finished), .i_phy_crc_good(i_phy_crc_good),
    .o_dbg_state(dbg_state)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  logic [2:0]  exp_q[$];
  logic [12:0] exp_len_q[$];
  int          stb_cnt  = 0;
  int          done_cnt = 0;
  int          exp_done = 0;
  bit          cur_write = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Monitor: checks length and gaps at each activate rise, pops tokens on strobes.
  logic        act_prev = 1'b0;
  logic [12:0] cnt_prev = 13'd0;
  int          low_cnt  = 0;
  bit          seen_pulse = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      act_prev = 1'b0; seen_pulse = 1'b0; low_cnt = 0;
      cnt_prev = o_phy_data_count;
    end else begin
      if (o_phy_activate && !act_prev) begin
        check("cnt_stable", o_phy_data_count, cnt_prev);
        if (exp_len_q.size() == 0) check("len_extra", exp_len_q.size(), 1);
        else check("len", o_phy_data_count, exp_len_q.pop_front());
        if (seen_pulse) check("gap", low_cnt, GAP + 2);
        seen_pulse = 1'b1;
        low_cnt = 0;
      end
      if (!o_phy_activate && o_busy) low_cnt++;
      if (!o_busy) begin seen_pulse = 1'b0; low_cnt = 0; end
      if (o_crc_status_stb) begin
        stb_cnt++;
        if (exp_q.size() == 0) check("tok_extra", exp_q.size(), 1);
        else check("token", o_crc_status, exp_q.pop_front());
      end
      if (o_done) done_cnt++;
      act_prev = o_phy_activate;
      cnt_prev = o_phy_data_count;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_xfer(input bit wr, input bit bm, input logic [8:0] bytes,
                            input logic [11:0] bsz, input logic [8:0] bcnt);
    i_write_flag = wr; i_block_mode = bm; i_byte_count = bytes;
    i_block_size = bsz; i_block_count = bcnt;
    i_xfer_start = 1'b1;
    tick();
    i_xfer_start = 1'b0;
    cur_write = wr;
    check("busy_after_start", o_busy, 1);
  endtask

  task automatic wait_act();
    for (int i = 0; i < 100 && !o_phy_activate; i++) tick();
    check("act_wait", o_phy_activate, 1);
  endtask

  task automatic run_block(input int lat, input bit good);
    wait_act();
    repeat (lat) tick();
    i_phy_finished = 1'b1;
    i_phy_crc_good = good;
    if (cur_write) exp_q.push_back(good ? 3'b010 : 3'b101);
    tick();
    i_phy_finished = 1'b0;
    i_phy_crc_good = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && !o_done; i++) tick();
    check("done_wait", o_done, 1);
  endtask

  initial begin
    int stb_before;
    int bcnt, bsz;
    rst = 1'b1;
    i_xfer_start = 0; i_write_flag = 0; i_block_mode = 0; i_abort = 0;
    i_byte_count = 0; i_block_size = 0; i_block_count = 0;
    i_phy_finished = 0; i_phy_crc_good = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_act", o_phy_activate, 0);
    check("rst_blocks", o_blocks_done, 0);
    check("rst_count", o_phy_data_count, 0);
    check("rst_status", o_crc_status, 0);
    check("rst_dbg", dbg_state, 0);

    // Byte-mode write, count 0 -> 512
    exp_len_q.push_back(13'd512);
    start_xfer(1, 0, 9'd0, 12'd0, 9'd0);
    check("setup_act_low", o_phy_activate, 0);
    check("setup_cnt512", o_phy_data_count, 512);
    check("setup_wflag", o_phy_write_flag, 1);
    tick();
    check("act_rise", o_phy_activate, 1);
    run_block(3, 1);
    wait_done();
    exp_done++;
    check("t1_blocks", o_blocks_done, 1);
    check("t1_crc_err", o_crc_error, 0);
    check("t1_busy", o_busy, 0);
    tick();

    // Block-mode read, 3 x 64; crc_good=0 must be ignored on reads
    stb_before = stb_cnt;
    repeat (3) exp_len_q.push_back(13'd64);
    start_xfer(0, 1, 9'd0, 12'd64, 9'd3);
    repeat (3) run_block(2, 0);
    wait_done();
    exp_done++;
    check("t2_blocks", o_blocks_done, 3);
    check("t2_crc_err", o_crc_error, 0);
    tick();
    check("t2_no_stb", stb_cnt, stb_before);

    // Block-mode write of 4, second block bad CRC stops transfer
    repeat (2) exp_len_q.push_back(13'd100);
    start_xfer(1, 1, 9'd0, 12'd100, 9'd4);
    run_block(1, 1);
    run_block(1, 0);
    wait_done();
    exp_done++;
    check("t3_blocks", o_blocks_done, 2);
    check("t3_crc_err", o_crc_error, 1);
    repeat (4) tick();

    // Unbounded read, size 0 -> 2048, abort mid sixth block
    repeat (6) exp_len_q.push_back(13'd2048);
    start_xfer(0, 1, 9'd0, 12'd0, 9'd0);
    check("t4_cnt2048", o_phy_data_count, 2048);
    check("t4_crc_err_cleared", o_crc_error, 0);
    repeat (5) run_block(1, 1);
    wait_act();
    tick(); tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    exp_done++;
    check("t4_act_low", o_phy_activate, 0);
    check("t4_aborted", o_aborted, 1);
    check("t4_blocks", o_blocks_done, 5);
    check("t4_done", o_done, 1);
    tick();

    // Abort coinciding with finish on a write
    exp_len_q.push_back(13'd17);
    start_xfer(1, 0, 9'd17, 12'd0, 9'd0);
    check("t5_aborted_cleared", o_aborted, 0);
    wait_act();
    tick();
    i_phy_finished = 1'b1; i_phy_crc_good = 1'b1; i_abort = 1'b1;
    exp_q.push_back(3'b010);
    tick();
    i_phy_finished = 1'b0; i_phy_crc_good = 1'b0; i_abort = 1'b0;
    exp_done++;
    check("t5_blocks", o_blocks_done, 1);
    check("t5_aborted", o_aborted, 1);
    check("t5_done", o_done, 1);
    check("t5_crc_err", o_crc_error, 0);
    tick();

    // Start while busy ignored; abort in idle ignored
    repeat (2) exp_len_q.push_back(13'd8);
    start_xfer(0, 1, 9'd0, 12'd8, 9'd2);
    wait_act();
    i_xfer_start = 1'b1; i_write_flag = 1'b1; i_block_mode = 1'b0; i_byte_count = 9'd5;
    tick();
    i_xfer_start = 1'b0;
    check("t6_wflag_held", o_phy_write_flag, 0);
    check("t6_cnt_held", o_phy_data_count, 8);
    run_block(1, 1);
    run_block(1, 1);
    wait_done();
    exp_done++;
    check("t6_blocks", o_blocks_done, 2);
    check("t6_aborted", o_aborted, 0);
    tick();
    i_abort = 1'b1;
    tick(); tick();
    i_abort = 1'b0;
    check("t6_idle_busy", o_busy, 0);
    check("t6_idle_aborted", o_aborted, 0);
    check("t6_idle_done", o_done, 0);

    // Reset mid-ACTIVE
    exp_len_q.push_back(13'd33);
    start_xfer(1, 0, 9'd33, 12'd0, 9'd0);
    wait_act();
    tick();
    rst = 1'b1;
    tick();
    check("t7_act", o_phy_activate, 0);
    check("t7_busy", o_busy, 0);
    check("t7_done", o_done, 0);
    check("t7_blocks", o_blocks_done, 0);
    check("t7_count", o_phy_data_count, 0);
    check("t7_wflag", o_phy_write_flag, 0);
    rst = 1'b0;
    repeat (3) tick();

    // Random bounded block writes
    for (int k = 0; k < 4; k++) begin
      bcnt = $urandom_range(1, 3);
      bsz  = $urandom_range(1, 40);
      for (int b = 0; b < bcnt; b++) exp_len_q.push_back(13'(bsz));
      start_xfer(1, 1, 9'd0, 12'(bsz), 9'(bcnt));
      for (int b = 0; b < bcnt; b++) run_block($urandom_range(0, 3), 1);
      wait_done();
      exp_done++;
      check("rnd_blocks", o_blocks_done, bcnt);
      tick();
    end

    repeat (3) tick();
    check("len_left", exp_len_q.size(), 0);
    check("tok_left", exp_q.size(), 0);
    check("done_pulses", done_cnt, exp_done);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sdio_data_control.md
Name: sdio_data_control

Overview:
Sequences the SDIO data PHY for a full CMD53 transfer. Splits a byte-mode or block-mode transfer into per-block PHY activations and drives the PHY activate, direction and count controls. Enforces inter-block gaps, collects write CRC results into CRC-status tokens, and handles abort. Sits between the function/command layer (CMD53 decode) and the data PHY.

Parameters:
GAP_CYCLES, 2, idle clk cycles between PHY deactivation and the next block's activation (min 1)
TIMEOUT_CYCLES, 65535, max clk cycles ACTIVE may last per block (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_xfer_start  in  1  start pulse; sampled only in IDLE
i_write_flag  in  1  1 = host-to-card (write), 0 = card-to-host (read)
i_block_mode  in  1  1 = block mode, 0 = byte mode
i_byte_count  in  9  byte-mode length; 0 means 512
i_block_size  in  12  block-mode block length; 0 means 2048
i_block_count  in  9  block-mode block count; 0 means unbounded (until abort)
i_abort  in  1  terminate transfer (CMD52 abort)
o_busy  out  1  transfer in progress
o_done  out  1  one-cycle pulse at end of transfer
o_aborted  out  1  sticky until next start: transfer ended by abort
o_crc_error  out  1  sticky until next start: a write block failed CRC
o_blocks_done  out  9  completed blocks this transfer (wraps at 511)
o_crc_status_stb  out  1  one-cycle pulse per finished write block
o_crc_status  out  3  CRC token: 3'b010 good, 3'b101 bad
o_phy_activate  out  1  to PHY i_activate
o_phy_write_flag  out  1  to PHY i_write_flag
o_phy_data_count  out  13  to PHY i_data_count
i_phy_finished  in  1  from PHY o_finished
i_phy_crc_good  in  1  from PHY o_data_crc_good

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0.
- State IDLE: on i_xfer_start, do the following and go to SETUP (o_busy=1 next cycle):
  - latch write flag, mode and counts;
  - clear o_aborted, o_crc_error, o_blocks_done.
- Length is latched in IDLE and held constant for the transfer:
  - byte mode: len = (i_byte_count==0) ? 512 : i_byte_count;
  - block mode: len = (i_block_size==0) ? 2048 : i_block_size;
  - zero-extend len to 13 bits onto o_phy_data_count.
- Byte mode is always exactly one block.
- SETUP (1 cycle): drive o_phy_write_flag and o_phy_data_count; go to ACTIVE with o_phy_activate=1 in the same registered update.
  - Count and flag are stable at least 1 cycle before activate rises and remain stable while activate is high.
- ACTIVE: hold activate. When i_phy_finished=1:
  - increment o_blocks_done;
  - if write: pulse o_crc_status_stb with token from i_phy_crc_good; on bad CRC set o_crc_error;
  - go to RELEASE.
- Read-direction i_phy_crc_good is ignored.
- RELEASE: o_phy_activate=0 for at least 1 cycle. Next state:
  - DONE if the write CRC failed, or i_block_count!=0 and blocks_done==i_block_count, or byte mode;
  - otherwise GAP.
- GAP: count GAP_CYCLES cycles with activate low, then SETUP.
- DONE: o_done=1 for one cycle, o_busy=0, o_phy_activate=0; then IDLE.
- Abort:
  - i_abort in any state other than IDLE/DONE: next cycle activate=0, o_aborted=1, go to DONE.
  - If i_abort and i_phy_finished coincide: the block is counted and its status token is emitted, then abort wins.
  - i_abort in IDLE is ignored.
- i_xfer_start while busy is ignored.
- Unbounded block mode (i_block_count==0) runs until abort or write CRC failure. o_blocks_done wraps 511→0.
- rst asserted mid-transfer: activate drops on the next clk, everything returns to reset values, no o_done pulse.

Optional Feature:
SDIO_DATA_TIMEOUT_EN
- Defined:
  - a 16-bit counter clears on entry to ACTIVE and increments each ACTIVE cycle;
  - reaching TIMEOUT_CYCLES without i_phy_finished drops activate, sets extra output o_timeout (sticky until next start, reset 0) and goes to DONE;
  - the timed-out block is not counted.
- Undefined: no counter, no o_timeout port; ACTIVE waits indefinitely.

Test Plan:
- Byte-mode write, i_byte_count=0 (512), PHY finished with crc_good=1:
  - o_phy_data_count=512 and activate high 1 cycle after SETUP;
  - one status strobe with 3'b010; o_blocks_done=1; o_done pulses; o_crc_error=0.
- Block-mode read, block_size=64, block_count=3, GAP_CYCLES=2:
  - three activate pulses, each separated by ≥1 RELEASE cycle plus 2 gap cycles;
  - no status strobes; o_blocks_done=3; single o_done.
- Block-mode write, block_count=4, second block crc_good=0:
  - tokens 3'b010 then 3'b101; transfer stops; o_blocks_done=2; o_crc_error=1; o_done pulses.
- Unbounded read (block_count=0, block_size=0→2048):
  - o_phy_data_count=2048;
  - after 5 blocks assert i_abort mid-block: activate low next cycle, o_aborted=1, o_blocks_done=5, o_done.
- i_abort in the same cycle as i_phy_finished on a write:
  - block counted; token emitted; o_aborted=1.
- i_xfer_start while busy and i_abort while idle: no effect. rst mid-ACTIVE: all outputs 0 next cycle, no o_done.
